sdcard_register_file: RTL and testbench

- Register file directly downstream of the SD controller's APB3 slave; consumes its reg_read/reg_write/reg_addr/reg_data_out strobes and returns reg_data_in/reg_ready/reg_error.
- Holds the controller configuration, command/argument, response, interrupt and data-port registers, word-aligned in the 0x000x5C window.
- Drives the command/data engines and the TX/RX FIFOs; raises irq_o.

---
 rtl/sdcard_register_file_pkg.sv | 42 ++++
 rtl/sdcard_register_file_if.sv | 20 ++
 rtl/sdcard_register_file_irq_ctrl.sv | 49 ++++
 rtl/sdcard_register_file.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_sdcard_register_file.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdcard_register_file_pkg.sv
// rtl/sdcard_register_file_pkg.sv - address map, reset values, irq bits, FSM states and lock keys
package sdcard_reg_pkg;

  localparam logic [15:0] SDCARD_REG_CTRL_ADDR     = 16'h0000;
  localparam logic [15:0] SDCARD_REG_CLKDIV_ADDR   = 16'h0004;
  localparam logic [15:0] SDCARD_REG_CMD_ADDR      = 16'h0008;
  localparam logic [15:0] SDCARD_REG_ARG_ADDR      = 16'h000C;
  localparam logic [15:0] SDCARD_REG_RESP0_ADDR    = 16'h0010;
  localparam logic [15:0] SDCARD_REG_RESP1_ADDR    = 16'h0014;
  localparam logic [15:0] SDCARD_REG_RESP2_ADDR    = 16'h0018;
  localparam logic [15:0] SDCARD_REG_RESP3_ADDR    = 16'h001C;
  localparam logic [15:0] SDCARD_REG_STATUS_ADDR   = 16'h0020;
  localparam logic [15:0] SDCARD_REG_INT_STAT_ADDR = 16'h0024;
  localparam logic [15:0] SDCARD_REG_INT_EN_ADDR   = 16'h0028;
  localparam logic [15:0] SDCARD_REG_BLKSIZE_ADDR  = 16'h002C;
  localparam logic [15:0] SDCARD_REG_BLKCNT_ADDR   = 16'h0030;
  localparam logic [15:0] SDCARD_REG_TIMEOUT_ADDR  = 16'h0034;
  localparam logic [15:0] SDCARD_REG_DATA_ADDR     = 16'h0038;
  localparam logic [15:0] SDCARD_REG_LOCK_ADDR     = 16'h003C;
  localparam logic [15:0] SDCARD_REG_VERSION_ADDR  = 16'h005C;

  localparam logic [15:0] SDCARD_CLKDIV_RST  = 16'h00FA;
  localparam logic [11:0] SDCARD_BLKSIZE_RST = 12'h200;
  localparam logic [31:0] SDCARD_TIMEOUT_RST = 32'h000F_FFFF;

  localparam int SDCARD_IRQ_CMD_DONE  = 0;
  localparam int SDCARD_IRQ_XFER_DONE = 1;
  localparam int SDCARD_IRQ_CMD_ERR   = 2;
  localparam int SDCARD_IRQ_DATA_ERR  = 3;
  localparam int SDCARD_IRQ_TIMEOUT   = 4;
  localparam int SDCARD_IRQ_RX_AVAIL  = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_RX = 2'd1,
    ST_RESP    = 2'd2
  } sdcard_reg_state_e;

  localparam logic [31:0] SDCARD_LOCK_KEY   = 32'h5A5A_A5A5;
  localparam logic [31:0] SDCARD_UNLOCK_KEY = 32'hA5A5_5A5A;

endpackage

// File: rtl/sdcard_register_file_if.sv
// rtl/sdcard_register_file_if.sv - register access bus between APB slave and register file
interface sdcard_reg_if;
  logic [15:0] reg_addr;
  logic        reg_read;
  logic        reg_write;
  logic [31:0] reg_data_out;
  logic [31:0] reg_data_in;
  logic        reg_ready;
  logic        reg_error;

  modport master (
    output reg_addr, reg_read, reg_write, reg_data_out,
    input  reg_data_in, reg_ready, reg_error
  );

  modport slave (
    input  reg_addr, reg_read, reg_write, reg_data_out,
    output reg_data_in, reg_ready, reg_error
  );
endinterface

// File: rtl/sdcard_register_file_irq_ctrl.sv
// rtl/sdcard_register_file_irq_ctrl.sv - W1C interrupt status, enable mask and registered irq
import sdcard_reg_pkg::*;

module sdcard_irq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] event_i,
  input  logic       stat_w1c_i,
  input  logic       en_we_i,
  input  logic       clr_all_i,
  input  logic [5:0] wdata_i,
  output logic [5:0] stat_o,
  output logic [5:0] en_o,
  output logic       irq_o
);

  logic [5:0] stat_q, stat_d;
  logic [5:0] en_q, en_d;
  logic       irq_q, irq_d;

  // Status: clears first, then new events are OR-ed in so a coincident event wins
  always_comb begin
    stat_d = stat_q;
    en_d   = en_q;
    if (clr_all_i) stat_d = 6'd0;
    if (stat_w1c_i) stat_d = stat_d & ~wdata_i;
    stat_d = stat_d | event_i;
    if (en_we_i) en_d = wdata_i;
    irq_d = |(stat_q & en_q);
  end

  // Status, enable and irq registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= 6'd0;
      en_q   <= 6'd0;
      irq_q  <= 1'b0;
    end else begin
      stat_q <= stat_d;
      en_q   <= en_d;
      irq_q  <= irq_d;
    end
  end

  assign stat_o = stat_q;
  assign en_o   = en_q;
  assign irq_o  = irq_q;

endmodule

// File: rtl/sdcard_register_file.sv
// rtl/sdcard_register_file.sv - SD controller register file; optional lock register under SDCARD_REG_LOCK_EN
import sdcard_reg_pkg::*;

module sdcard_register_file #(
  parameter int          FIFO_WAIT_CYCLES = 16,
  parameter logic [31:0] VERSION_ID       = 32'h0001_0000
) (
  input  logic         PCLK_i,
  input  logic         PRESET_i,
  sdcard_reg_if.slave  bus,
  output logic         sd_enable_o,
  output logic [1:0]   bus_width_o,
  output logic [15:0]  clk_div_o,
  output logic         soft_rst_o,
  output logic         cmd_start_o,
  output logic [5:0]   cmd_index_o,
  output logic [1:0]   cmd_resp_type_o,
  output logic         cmd_data_o,
  output logic [31:0]  cmd_arg_o,
  output logic [11:0]  blk_size_o,
  output logic [15:0]  blk_cnt_o,
  output logic [31:0]  timeout_o,
  input  logic         cmd_busy_i,
  input  logic         dat_busy_i,
  input  logic         resp_valid_i,
  input  logic [127:0] resp_i,
  input  logic [5:0]   irq_event_i,
  output logic         tx_push_o,
  output logic [31:0]  tx_wdata_o,
  input  logic         tx_full_i,
  output logic         rx_pop_o,
  input  logic [31:0]  rx_rdata_i,
  input  logic         rx_empty_i,
  output logic         irq_o
);

  localparam int CW = $clog2(FIFO_WAIT_CYCLES + 1);

  sdcard_reg_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          enable_q, enable_d;
  logic [1:0]    bw_q, bw_d;
  logic [15:0]   clkdiv_q, clkdiv_d;
  logic [8:0]    cmd_q, cmd_d;
  logic [31:0]   arg_q, arg_d;
  logic [11:0]   blksize_q, blksize_d;
  logic [15:0]   blkcnt_q, blkcnt_d;
  logic [31:0]   timeout_q, timeout_d;
  logic [31:0]   resp_q [4];
  logic [31:0]   resp_d [4];
  logic          soft_rst_q, soft_rst_d;
  logic          cmd_start_q, cmd_start_d;
  logic          tx_push_q, tx_push_d;
  logic [31:0]   tx_wdata_q, tx_wdata_d;
  logic          rx_pop_q, rx_pop_d;
  logic          stat_w1c, en_we, clr_stat;
  logic [5:0]    int_stat, int_en;
  logic [31:0]   rd_val;
  logic          req, bad_addr, wr_locked;
  logic [15:0]   addr;

`ifdef SDCARD_REG_LOCK_EN
  logic lock_q, lock_d;
  assign wr_locked = lock_q;
`else
  assign wr_locked = 1'b0;
`endif

  assign addr     = bus.reg_addr;
  assign req      = bus.reg_read | bus.reg_write;
  assign bad_addr = (addr[1:0] != 2'b00) || (addr > SDCARD_REG_VERSION_ADDR);

  sdcard_irq_ctrl u_irq (
    .clk        (PCLK_i),
    .rst        (PRESET_i),
    .event_i    (irq_event_i),
    .stat_w1c_i (stat_w1c),
    .en_we_i    (en_we),
    .clr_all_i  (clr_stat),
    .wdata_i    (bus.reg_data_out[5:0]),
    .stat_o     (int_stat),
    .en_o       (int_en),
    .irq_o      (irq_o)
  );

  // Read mux for the non-FIFO registers; reserved words read as zero
  always_comb begin
    rd_val = 32'd0;
    case (addr)
      SDCARD_REG_CTRL_ADDR:     rd_val = {28'd0, bw_q, 1'b0, enable_q};
      SDCARD_REG_CLKDIV_ADDR:   rd_val = {16'd0, clkdiv_q};
      SDCARD_REG_CMD_ADDR:      rd_val = {23'd0, cmd_q};
      SDCARD_REG_ARG_ADDR:      rd_val = arg_q;
      SDCARD_REG_RESP0_ADDR,
      SDCARD_REG_RESP1_ADDR,
      SDCARD_REG_RESP2_ADDR,
      SDCARD_REG_RESP3_ADDR:    rd_val = resp_q[addr[3:2]];
      SDCARD_REG_STATUS_ADDR:   rd_val = {28'd0, tx_full_i, rx_empty_i, dat_busy_i, cmd_busy_i};
      SDCARD_REG_INT_STAT_ADDR: rd_val = {26'd0, int_stat};
      SDCARD_REG_INT_EN_ADDR:   rd_val = {26'd0, int_en};
      SDCARD_REG_BLKSIZE_ADDR:  rd_val = {20'd0, blksize_q};
      SDCARD_REG_BLKCNT_ADDR:   rd_val = {16'd0, blkcnt_q};
      SDCARD_REG_TIMEOUT_ADDR:  rd_val = timeout_q;
`ifdef SDCARD_REG_LOCK_EN
      SDCARD_REG_LOCK_ADDR:     rd_val = {31'd0, lock_q};
`endif
      SDCARD_REG_VERSION_ADDR:  rd_val = VERSION_ID;
      default:                  rd_val = 32'd0;
    endcase
  end

  // Access FSM: decode and perform in IDLE, stall in WAIT_RX for the RX FIFO, answer in RESP
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    enable_d    = enable_q;
    bw_d        = bw_q;
    clkdiv_d    = clkdiv_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    blksize_d   = blksize_q;
    blkcnt_d    = blkcnt_q;
    timeout_d   = timeout_q;
    soft_rst_d  = 1'b0;
    cmd_start_d = 1'b0;
    tx_push_d   = 1'b0;
    tx_wdata_d  = tx_wdata_q;
    rx_pop_d    = 1'b0;
    stat_w1c    = 1'b0;
    en_we       = 1'b0;
    clr_stat    = 1'b0;
`ifdef SDCARD_REG_LOCK_EN
    lock_d      = lock_q;
`endif
    for (int i = 0; i < 4; i++) begin
      resp_d[i] = resp_valid_i ? resp_i[32*i +: 32] : resp_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = 32'd0;
          if (bad_addr) begin
            err_d = 1'b1;
          end else if (bus.reg_write) begin
            case (addr)
              SDCARD_REG_CTRL_ADDR: begin
                if (wr_locked) err_d = 1'b1;
                else begin
                  enable_d = bus.reg_data_out[0];
                  bw_d     = bus.reg_data_out[3:2];
                  if (bus.reg_data_out[1]) begin
                    soft_rst_d = 1'b1;
                    clr_stat   = 1'b1;
                  end
                end
              end
              SDCARD_REG_CLKDIV_ADDR: begin
                if (wr_locked) err_d = 1'b1;
                else clkdiv_d = bus.reg_data_out[15:0];
              end
              SDCARD_REG_CMD_ADDR: begin
                if (cmd_busy_i) err_d = 1'b1;
                else begin
                  cmd_d       = bus.reg_data_out[8:0];
                  cmd_start_d = 1'b1;
                end
              end
              SDCARD_REG_ARG_ADDR:      arg_d = bus.reg_data_out;
              SDCARD_REG_INT_STAT_ADDR: stat_w1c = 1'b1;
              SDCARD_REG_INT_EN_ADDR:   en_we = 1'b1;
              SDCARD_REG_BLKSIZE_ADDR: begin
                if (wr_locked) err_d = 1'b1;
                else blksize_d = bus.reg_data_out[11:0];
              end
              SDCARD_REG_BLKCNT_ADDR:   blkcnt_d = bus.reg_data_out[15:0];
              SDCARD_REG_TIMEOUT_ADDR: begin
                if (wr_locked) err_d = 1'b1;
                else timeout_d = bus.reg_data_out;
              end
              SDCARD_REG_DATA_ADDR: begin
                if (tx_full_i) err_d = 1'b1;
                else begin
                  tx_push_d  = 1'b1;
                  tx_wdata_d = bus.reg_data_out;
                end
              end
`ifdef SDCARD_REG_LOCK_EN
              SDCARD_REG_LOCK_ADDR: begin
                if (bus.reg_data_out == SDCARD_LOCK_KEY) lock_d = 1'b1;
                else if (bus.reg_data_out == SDCARD_UNLOCK_KEY) lock_d = 1'b0;
              end
`endif
              default: err_d = 1'b1;
            endcase
          end else if (addr == SDCARD_REG_DATA_ADDR) begin
            if (rx_empty_i) begin
              state_d = ST_WAIT_RX;
              cnt_d   = '0;
            end else begin
              rdata_d  = rx_rdata_i;
              rx_pop_d = 1'b1;
            end
          end else begin
            rdata_d = rd_val;
          end
        end
      end
      ST_WAIT_RX: begin
        if (!rx_empty_i) begin
          rdata_d  = rx_rdata_i;
          rx_pop_d = 1'b1;
          state_d  = ST_RESP;
        end else if (cnt_q == CW'(FIFO_WAIT_CYCLES - 1)) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, configuration and pulse registers
  always_ff @(posedge PCLK_i or posedge PRESET_i) begin
    if (PRESET_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      enable_q    <= 1'b0;
      bw_q        <= 2'd0;
      clkdiv_q    <= SDCARD_CLKDIV_RST;
      cmd_q       <= 9'd0;
      arg_q       <= 32'd0;
      blksize_q   <= SDCARD_BLKSIZE_RST;
      blkcnt_q    <= 16'd0;
      timeout_q   <= SDCARD_TIMEOUT_RST;
      for (int i = 0; i < 4; i++) resp_q[i] <= 32'd0;
      soft_rst_q  <= 1'b0;
      cmd_start_q <= 1'b0;
      tx_push_q   <= 1'b0;
      tx_wdata_q  <= 32'd0;
      rx_pop_q    <= 1'b0;
`ifdef SDCARD_REG_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      enable_q    <= enable_d;
      bw_q        <= bw_d;
      clkdiv_q    <= clkdiv_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
      blksize_q   <= blksize_d;
      blkcnt_q    <= blkcnt_d;
      timeout_q   <= timeout_d;
      for (int i = 0; i < 4; i++) resp_q[i] <= resp_d[i];
      soft_rst_q  <= soft_rst_d;
      cmd_start_q <= cmd_start_d;
      tx_push_q   <= tx_push_d;
      tx_wdata_q  <= tx_wdata_d;
      rx_pop_q    <= rx_pop_d;
`ifdef SDCARD_REG_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  assign bus.reg_ready    = (state_q == ST_RESP);
  assign bus.reg_data_in  = rdata_q;
  assign bus.reg_error    = err_q;
  assign sd_enable_o      = enable_q;
  assign bus_width_o      = bw_q;
  assign clk_div_o        = clkdiv_q;
  assign soft_rst_o       = soft_rst_q;
  assign cmd_start_o      = cmd_start_q;
  assign cmd_index_o      = cmd_q[5:0];
  assign cmd_resp_type_o  = cmd_q[7:6];
  assign cmd_data_o       = cmd_q[8];
  assign cmd_arg_o        = arg_q;
  assign blk_size_o       = blksize_q;
  assign blk_cnt_o        = blkcnt_q;
  assign timeout_o        = timeout_q;
  assign tx_push_o        = tx_push_q;
  assign tx_wdata_o       = tx_wdata_q;
  assign rx_pop_o         = rx_pop_q;

endmodule

// File: tb/tb_sdcard_register_file.sv
// tb/tb_sdcard_register_file.sv - self-checking bench for sdcard_register_file (SDCARD_REG_LOCK_EN aware)
module tb_sdcard_register_file;

  localparam int          FWC = 16;
  localparam logic [31:0] VID = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  sdcard_reg_if bus();

  logic sd_enable, soft_rst, cmd_start, cmd_data, tx_push, rx_pop, irq;
  logic [1:0]  bus_width, cmd_resp_type;
  logic [15:0] clk_div, blk_cnt;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg, timeout, tx_wdata;
  logic [11:0] blk_size;
  logic cmd_busy = 0, dat_busy = 0, resp_valid = 0, tx_full = 0, rx_empty = 1;
  logic [127:0] resp = '0;
  logic [5:0]   irq_event = '0;
  logic [31:0]  rx_rdata = '0;

  int total = 0;
  int bad = 0;
  int n_cmd_start = 0, n_soft_rst = 0, n_tx_push = 0, n_rx_pop = 0;
  logic [31:0] last_tx = '0;

  // behavioural model: word-indexed register image
  logic [31:0] reg_m [0:23];
  logic [31:0] resp_m [0:3];
  logic [5:0]  m_stat;
  bit          m_locked;

  sdcard_register_file #(.FIFO_WAIT_CYCLES(FWC), .VERSION_ID(VID)) dut (
    .PCLK_i(clk), .PRESET_i(rst), .bus(bus),
    .sd_enable_o(sd_enable), .bus_width_o(bus_width), .clk_div_o(clk_div),
    .soft_rst_o(soft_rst), .cmd_start_o(cmd_start), .cmd_index_o(cmd_index),
    .cmd_resp_type_o(cmd_resp_type), .cmd_data_o(cmd_data), .cmd_arg_o(cmd_arg),
    .blk_size_o(blk_size), .blk_cnt_o(blk_cnt), .timeout_o(timeout),
    .cmd_busy_i(cmd_busy), .dat_busy_i(dat_busy), .resp_valid_i(resp_valid),
    .resp_i(resp), .irq_event_i(irq_event), .tx_push_o(tx_push),
    .tx_wdata_o(tx_wdata), .tx_full_i(tx_full), .rx_pop_o(rx_pop),
    .rx_rdata_i(rx_rdata), .rx_empty_i(rx_empty), .irq_o(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_start) n_cmd_start++;
      if (soft_rst)  n_soft_rst++;
      if (rx_pop)    n_rx_pop++;
      if (tx_push) begin n_tx_push++; last_tx = tx_wdata; end
    end
  end

  function automatic bit m_is_rw(int idx);
    return (idx <= 3) || (idx >= 10 && idx <= 13);
  endfunction

  function automatic logic [31:0] m_mask(int idx);
    case (idx)
      0: return 32'h0000_000D;
      1: return 32'h0000_FFFF;
      2: return 32'h0000_01FF;
      10: return 32'h0000_003F;
      11: return 32'h0000_0FFF;
      12: return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic bit m_exp_err(bit wr, logic [15:0] a);
    int idx;
    idx = int'(a >> 2);
    if (a[1:0] != 2'b00 || a > 16'h005C) return 1;
    if (!wr) return 0;
    if (m_is_rw(idx)) return m_locked && (idx == 0 || idx == 1 || idx == 11 || idx == 13);
    if (idx == 9) return 0;
`ifdef SDCARD_REG_LOCK_EN
    if (idx == 15) return 0;
`endif
    return 1;
  endfunction

  function automatic logic [31:0] m_read(logic [15:0] a);
    int idx;
    idx = int'(a >> 2);
    if (m_is_rw(idx)) return reg_m[idx];
    if (idx >= 4 && idx <= 7) return resp_m[idx-4];
    if (idx == 8) return {28'd0, tx_full, rx_empty, dat_busy, cmd_busy};
    if (idx == 9) return {26'd0, m_stat};
`ifdef SDCARD_REG_LOCK_EN
    if (idx == 15) return {31'd0, m_locked};
`endif
    if (idx == 23) return VID;
    return 32'd0;
  endfunction

  task automatic m_write(logic [15:0] a, logic [31:0] d);
    int idx;
    idx = int'(a >> 2);
    if (m_exp_err(1'b1, a)) return;
    if (m_is_rw(idx)) reg_m[idx] = d & m_mask(idx);
    if (idx == 0 && d[1]) m_stat = 6'd0;
    if (idx == 9) m_stat = m_stat & ~d[5:0];
`ifdef SDCARD_REG_LOCK_EN
    if (idx == 15) begin
      if (d == 32'h5A5A_A5A5) m_locked = 1;
      else if (d == 32'hA5A5_5A5A) m_locked = 0;
    end
`endif
  endtask

  task automatic m_reset();
    for (int i = 0; i < 24; i++) reg_m[i] = 32'd0;
    for (int i = 0; i < 4; i++) resp_m[i] = 32'd0;
    reg_m[1] = 32'h0000_00FA;
    reg_m[11] = 32'h0000_0200;
    reg_m[13] = 32'h000F_FFFF;
    m_stat = 6'd0;
    m_locked = 0;
  endtask

  // single access, called at a negedge; lat = cycles from request to reg_ready
  task automatic access(input bit wr, input logic [15:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat, output logic rdy2);
    bus.reg_addr = a; bus.reg_write = wr; bus.reg_read = !wr; bus.reg_data_out = d;
    @(posedge clk);
    @(negedge clk);
    bus.reg_read = 0; bus.reg_write = 0;
    lat = 1;
    while (!bus.reg_ready && lat < 64) begin @(negedge clk); lat++; end
    rd = bus.reg_data_in; er = bus.reg_error;
    @(negedge clk);
    rdy2 = bus.reg_ready;
  endtask

  task automatic do_reset();
    rst = 1;
    bus.reg_read = 0; bus.reg_write = 0; bus.reg_addr = 0; bus.reg_data_out = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    m_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er, r2; int lat;
    logic [15:0] addrs [3];
    logic [31:0] exps [3];
    addrs = '{16'h0004, 16'h002C, 16'h005C};
    exps  = '{32'h0000_00FA, 32'h0000_0200, VID};
    total++; if (clk_div !== 16'h00FA || blk_size !== 12'h200 || timeout !== 32'h000F_FFFF) begin
      bad++; $display("FAIL reset_outputs clk_div=%h blk_size=%h timeout=%h", clk_div, blk_size, timeout); end
    total++; if ({sd_enable, bus_width, cmd_start, soft_rst, tx_push, rx_pop, irq, bus.reg_ready} !== 9'd0) begin
      bad++; $display("FAIL reset_zero_outputs got=%b required=0", {sd_enable, bus_width, cmd_start, soft_rst, tx_push, rx_pop, irq, bus.reg_ready}); end
    for (int i = 0; i < 3; i++) begin
      access(0, addrs[i], 0, rd, er, lat, r2);
      total++; if (rd !== exps[i] || er !== 1'b0 || lat != 1 || r2 !== 1'b0) begin
        bad++; $display("FAIL reset_read addr=%h data=%h err=%b lat=%0d ready2=%b required data=%h err=0 lat=1 ready2=0", addrs[i], rd, er, lat, r2, exps[i]); end
    end
  endtask

  task automatic test_cmd();
    logic [31:0] rd; logic er, r2; int lat, n0;
    n0 = n_cmd_start;
    access(1, 16'h0008, 32'h0000_0111, rd, er, lat, r2);
    m_write(16'h0008, 32'h0000_0111);
    total++; if (er !== 1'b0 || n_cmd_start != n0 + 1 || cmd_index !== 6'h11 || cmd_resp_type !== 2'd0 || cmd_data !== 1'b1) begin
      bad++; $display("FAIL cmd_write err=%b pulses=%0d idx=%h rt=%0d data=%b required err=0 pulses=1 idx=11 rt=0 data=1", er, n_cmd_start-n0, cmd_index, cmd_resp_type, cmd_data); end
    cmd_busy = 1;
    n0 = n_cmd_start;
    access(1, 16'h0008, 32'h0000_00C5, rd, er, lat, r2);
    total++; if (er !== 1'b1 || n_cmd_start != n0 || cmd_index !== 6'h11) begin
      bad++; $display("FAIL cmd_busy err=%b pulses=%0d idx=%h required err=1 pulses=0 idx=11", er, n_cmd_start-n0, cmd_index); end
    access(0, 16'h0008, 0, rd, er, lat, r2);
    total++; if (rd !== m_read(16'h0008) || er !== 1'b0) begin
      bad++; $display("FAIL cmd_readback data=%h err=%b required=%h", rd, er, m_read(16'h0008)); end
    cmd_busy = 0;
  endtask

  task automatic test_irq();
    logic [31:0] rd; logic er, r2; int lat;
    access(1, 16'h0028, 32'h0000_003C, rd, er, lat, r2);
    m_write(16'h0028, 32'h3C);
    irq_event = 6'b000100;
    @(negedge clk);
    irq_event = 6'b0;
    m_stat = m_stat | 6'b000100;
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_raise irq=%b required=1", irq); end
    // W1C of bit 2 in the same cycle as a fresh bit-2 event
    bus.reg_addr = 16'h0024; bus.reg_write = 1; bus.reg_data_out = 32'h4; irq_event = 6'b000100;
    @(posedge clk);
    @(negedge clk);
    bus.reg_write = 0; irq_event = 6'b0;
    @(negedge clk);
    m_stat = (m_stat & ~6'b000100) | 6'b000100;
    access(0, 16'h0024, 0, rd, er, lat, r2);
    total++; if (rd !== {26'd0, m_stat} || er !== 1'b0) begin
      bad++; $display("FAIL irq_w1c_race stat=%h required=%h", rd, m_stat); end
    access(1, 16'h0024, 32'h4, rd, er, lat, r2);
    m_write(16'h0024, 32'h4);
    access(0, 16'h0024, 0, rd, er, lat, r2);
    total++; if (rd !== {26'd0, m_stat}) begin bad++; $display("FAIL irq_w1c_clear stat=%h required=%h", rd, m_stat); end
    repeat (2) @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_drop irq=%b required=0", irq); end
  endtask

  task automatic test_data();
    logic [31:0] rd, v; logic er, r2; int lat, n0;
    v = $urandom;
    n0 = n_tx_push;
    access(1, 16'h0038, v, rd, er, lat, r2);
    total++; if (er !== 1'b0 || n_tx_push != n0 + 1 || last_tx !== v) begin
      bad++; $display("FAIL data_write err=%b pushes=%0d wdata=%h required err=0 pushes=1 wdata=%h", er, n_tx_push-n0, last_tx, v); end
    tx_full = 1;
    n0 = n_tx_push;
    access(1, 16'h0038, v, rd, er, lat, r2);
    total++; if (er !== 1'b1 || n_tx_push != n0) begin
      bad++; $display("FAIL data_write_full err=%b pushes=%0d required err=1 pushes=0", er, n_tx_push-n0); end
    tx_full = 0;
    v = $urandom; rx_rdata = v; rx_empty = 0;
    n0 = n_rx_pop;
    access(0, 16'h0038, 0, rd, er, lat, r2);
    rx_empty = 1;
    total++; if (rd !== v || er !== 1'b0 || lat != 1 || n_rx_pop != n0 + 1) begin
      bad++; $display("FAIL data_read_ready data=%h err=%b lat=%0d pops=%0d required data=%h err=0 lat=1 pops=1", rd, er, lat, n_rx_pop-n0, v); end
    n0 = n_rx_pop;
    fork
      access(0, 16'h0038, 0, rd, er, lat, r2);
      begin
        repeat (5) @(posedge clk);
        #1 rx_rdata = 32'hDEAD_BEEF; rx_empty = 0;
        @(posedge clk);
        #1 rx_empty = 1;
      end
    join
    total++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat != 6 || n_rx_pop != n0 + 1) begin
      bad++; $display("FAIL data_read_wait data=%h err=%b lat=%0d pops=%0d required data=deadbeef err=0 lat=6 pops=1", rd, er, lat, n_rx_pop-n0); end
    n0 = n_rx_pop;
    access(0, 16'h0038, 0, rd, er, lat, r2);
    total++; if (rd !== 32'd0 || er !== 1'b1 || lat < FWC || lat > FWC + 2 || n_rx_pop != n0) begin
      bad++; $display("FAIL data_read_timeout data=%h err=%b lat=%0d pops=%0d required data=0 err=1 lat~%0d pops=0", rd, er, lat, n_rx_pop-n0, FWC); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er, r2; int lat;
    access(1, 16'h0010, 32'h1234, rd, er, lat, r2);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL err_write_ro err=%b required=1", er); end
    access(0, 16'h0060, 0, rd, er, lat, r2);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL err_read_oor err=%b required=1", er); end
    access(0, 16'h0002, 0, rd, er, lat, r2);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL err_unaligned err=%b required=1", er); end
    access(0, 16'h0040, 0, rd, er, lat, r2);
    total++; if (rd !== 32'd0 || er !== 1'b0) begin bad++; $display("FAIL reserved_read data=%h err=%b required 0/0", rd, er); end
    cmd_busy = 1; dat_busy = 0; tx_full = 1; rx_empty = 1;
    access(0, 16'h0020, 0, rd, er, lat, r2);
    total++; if (rd !== 32'hD || er !== 1'b0) begin bad++; $display("FAIL status data=%h required=0000000d", rd); end
    cmd_busy = 0; tx_full = 0;
  endtask

  task automatic test_resp();
    logic [31:0] rd; logic er, r2; int lat;
    resp = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) resp_m[i] = resp[32*i +: 32];
    resp_valid = 1;
    @(negedge clk);
    resp_valid = 0; resp = '0;
    for (int i = 0; i < 4; i++) begin
      access(0, 16'h0010 + 16'(4*i), 0, rd, er, lat, r2);
      total++; if (rd !== resp_m[i] || er !== 1'b0) begin
        bad++; $display("FAIL resp%0d data=%h required=%h", i, rd, resp_m[i]); end
    end
  endtask

`ifdef SDCARD_REG_LOCK_EN
  task automatic test_lock();
    logic [31:0] rd; logic er, r2; int lat;
    access(1, 16'h003C, 32'h5A5A_A5A5, rd, er, lat, r2); m_write(16'h003C, 32'h5A5A_A5A5);
    access(1, 16'h0004, 32'h1234, rd, er, lat, r2);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL lock_write_err err=%b required=1", er); end
    access(0, 16'h0004, 0, rd, er, lat, r2);
    total++; if (rd !== 32'h00FA) begin bad++; $display("FAIL lock_readback data=%h required=000000fa", rd); end
    access(0, 16'h003C, 0, rd, er, lat, r2);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL lock_state data=%h required=1", rd); end
    access(1, 16'h003C, 32'hA5A5_5A5A, rd, er, lat, r2); m_write(16'h003C, 32'hA5A5_5A5A);
    access(1, 16'h0004, 32'h1234, rd, er, lat, r2); m_write(16'h0004, 32'h1234);
    total++; if (er !== 1'b0 || clk_div !== 16'h1234) begin
      bad++; $display("FAIL unlock_write err=%b clk_div=%h required 0/1234", er, clk_div); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] rd, d, exp_d; logic er, r2, exp_e; int lat;
    logic [15:0] a;
    bit wr;
    for (int n = 0; n < 60; n++) begin
      do begin
        a = 16'($urandom_range(0, 30) * 4);
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      end while (a == 16'h0038);
      wr = $urandom_range(0, 1) == 1;
      d = $urandom;
      exp_d = m_read(a);
      exp_e = m_exp_err(wr, a);
      access(wr, a, d, rd, er, lat, r2);
      if (wr) m_write(a, d);
      total++; if (er !== exp_e || lat != 1 || r2 !== 1'b0 || (!wr && !exp_e && rd !== exp_d)) begin
        bad++; $display("FAIL random wr=%0d addr=%h data=%h err=%b lat=%0d required data=%h err=%b lat=1", wr, a, rd, er, lat, exp_d, exp_e); end
    end
    total++; if ({sd_enable, bus_width} !== {reg_m[0][0], reg_m[0][3:2]} || clk_div !== reg_m[1][15:0] ||
                 cmd_arg !== reg_m[3] || blk_size !== reg_m[11][11:0] || blk_cnt !== reg_m[12][15:0] ||
                 timeout !== reg_m[13] || cmd_index !== reg_m[2][5:0]) begin
      bad++; $display("FAIL random_outputs clk_div=%h arg=%h blk_size=%h blk_cnt=%h timeout=%h required %h %h %h %h %h",
                      clk_div, cmd_arg, blk_size, blk_cnt, timeout, reg_m[1][15:0], reg_m[3], reg_m[11][11:0], reg_m[12][15:0], reg_m[13]); end
  endtask

  task automatic test_reset_mid();
    bus.reg_addr = 16'h0008; bus.reg_write = 1; bus.reg_data_out = 32'h3F;
    @(posedge clk);
    #1 rst = 1;
    #1;
    total++; if (bus.reg_ready !== 1'b0 || cmd_start !== 1'b0 || clk_div !== 16'h00FA) begin
      bad++; $display("FAIL reset_mid ready=%b cmd_start=%b clk_div=%h required 0/0/00fa", bus.reg_ready, cmd_start, clk_div); end
    bus.reg_write = 0;
    @(negedge clk);
    rst = 0;
    m_reset();
    @(negedge clk);
    total++; if (bus.reg_ready !== 1'b0 || cmd_index !== 6'd0) begin
      bad++; $display("FAIL reset_mid_after ready=%b idx=%h required 0/0", bus.reg_ready, cmd_index); end
  endtask

  initial begin
    do_reset();
    test_reset();
`ifdef SDCARD_REG_LOCK_EN
    test_lock();
`endif
    test_cmd();
    test_irq();
    test_data();
    test_errors();
    test_resp();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
